// File: rtl/pr_elastic_pkg.sv
// pr_elastic_pkg: shared state encoding and depth constant for the elastic pipeline register
package pr_pkg;
  typedef enum logic [1:0] {PR_EMPTY, PR_ONE, PR_FULL} pr_state_e;
  localparam int PR_SKID_DEPTH = 2;
endpackage

// File: rtl/pr_elastic_if.sv
// pr_elastic_if: upstream/downstream handshake bundle plus hazard controls
interface pr_elastic_if #(parameter int WIDTH = 32, parameter int TAG_W = 20);
  logic i_stall, i_flush, i_valid, o_ready, o_valid, i_ready;
  logic [WIDTH-1:0] i_data, o_data, o_data_next;
  logic [TAG_W-1:0] i_tag, o_tag;
  logic [1:0] o_occupancy;
  modport slave (input i_stall, i_flush, i_valid, i_data, i_tag, i_ready,
                 output o_ready, o_valid, o_data, o_tag, o_data_next, o_occupancy);
  modport master (output i_stall, i_flush, i_valid, i_data, i_tag, i_ready,
                  input o_ready, o_valid, o_data, o_tag, o_data_next, o_occupancy);
endinterface

// File: rtl/pr_elastic_slot.sv
// pr_slot: one storage entry (payload+tag word with valid flag); clear beats load beats drop
module pr_slot #(
  parameter int W = 52,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= RESET_VAL;
      valid <= 1'b0;
    end else if (clear) begin
      q <= RESET_VAL;
      valid <= 1'b0;
    end else if (load) begin
      q <= d;
      valid <= 1'b1;
    end else if (drop) valid <= 1'b0;
endmodule

// File: rtl/pr_elastic.sv
// pr_elastic: elastic pipeline register with optional skid entry, hazard stall/flush and lookahead data
module pr_elastic import pr_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 20,
  parameter bit SKID = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input logic clk,
  input logic rst,
  pr_elastic_if.slave bus
);
  localparam int W = WIDTH + TAG_W;
  localparam logic [W-1:0] RV = {RESET_DATA, {TAG_W{1'b0}}};
  pr_state_e state, state_n;
  logic rdy_q, push, pop, kill, main_v, skid_v, main_ld;
  logic [W-1:0] main_q, skid_q, main_d;
  assign kill = bus.i_flush & !bus.i_stall;
  assign bus.o_valid = main_v;
  assign bus.o_ready = (SKID ? rdy_q : (!main_v | bus.i_ready)) & !bus.i_stall;
  assign push = bus.i_valid & bus.o_ready & !bus.i_stall & !bus.i_flush;
  assign pop = main_v & bus.i_ready & !bus.i_stall & !bus.i_flush;
  assign main_ld = (state == PR_EMPTY & push) | (state == PR_ONE & push & pop) | (state == PR_FULL & pop);
  assign main_d = state == PR_FULL ? skid_q : {bus.i_data, bus.i_tag};
  always_comb
    state_n = kill ? PR_EMPTY :
              state == PR_EMPTY ? (push ? PR_ONE : PR_EMPTY) :
              state == PR_ONE ? (push & !pop ? PR_FULL : (!push & pop ? PR_EMPTY : PR_ONE)) :
              (pop ? PR_ONE : PR_FULL);
  // ready is registered from the next state so backpressure never depends on i_ready combinationally
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= PR_EMPTY;
      rdy_q <= 1'b1;
    end else if (!bus.i_stall) begin
      state <= state_n;
      rdy_q <= state_n != PR_FULL;
    end
  pr_slot #(.W(W), .RESET_VAL(RV)) u_main (
    .clk(clk), .rst(rst), .load(main_ld), .clear(kill),
    .drop(state == PR_ONE & pop & !push), .d(main_d), .q(main_q), .valid(main_v)
  );
  if (SKID) begin : g_skid
    pr_slot #(.W(W), .RESET_VAL(RV)) u_skid (
      .clk(clk), .rst(rst), .load(state == PR_ONE & push & !pop), .clear(kill),
      .drop(state == PR_FULL & pop), .d({bus.i_data, bus.i_tag}), .q(skid_q), .valid(skid_v)
    );
  end else begin : g_noskid
    assign skid_q = RV;
    assign skid_v = 1'b0;
  end
  assign bus.o_data = main_q[W-1:TAG_W];
  assign bus.o_tag = main_q[TAG_W-1:0];
  assign bus.o_data_next = bus.i_stall ? bus.o_data : bus.i_flush ? RESET_DATA :
                           main_ld ? main_d[W-1:TAG_W] : bus.o_data;
  assign bus.o_occupancy = {1'b0, main_v} + {1'b0, skid_v};
endmodule
